// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word decoder: opcodes, control bundle
// layout, statistics class indices and the bundle-to-opcode decode function.
package ctrl_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b111;
  localparam logic [2:0] OP_ADDI  = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b001;

  localparam int NUM_CLASSES = 8;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_ADDI    = 3'd4,
    CLS_NOP     = 3'd5,
    CLS_ILLEGAL = 3'd6,
    CLS_TOTAL   = 3'd7
  } class_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic       illegal;
    class_e     cls;
  } decode_t;

  // SW and BEQ leave RegDst and MemtoReg as don't-care; mask them out.
  localparam logic [8:0] DONT_CARE_MASK = 9'b010111111;

  function automatic decode_t decode_bundle(input ctrl_bundle_t b);
    decode_t    d;
    logic [8:0] raw;
    logic [8:0] masked;
    raw    = b;
    masked = raw & DONT_CARE_MASK;
    // NOTE: every field gets a default before the match chain, so no path
    // through this combinational logic can leave a value unassigned (no latch).
    d.opcode  = OP_RTYPE;
    d.illegal = 1'b1;
    d.cls     = CLS_ILLEGAL;
    if (raw == 9'b100100010) begin
      d = '{opcode: OP_RTYPE, illegal: 1'b0, cls: CLS_RTYPE};
    end else if (raw == 9'b011110000) begin
      d = '{opcode: OP_LW, illegal: 1'b0, cls: CLS_LW};
    end else if (masked == 9'b010001000) begin
      d = '{opcode: OP_SW, illegal: 1'b0, cls: CLS_SW};
    end else if (masked == 9'b000000101) begin
      d = '{opcode: OP_BEQ, illegal: 1'b0, cls: CLS_BEQ};
    end else if (raw == 9'b010100000) begin
      d = '{opcode: OP_ADDI, illegal: 1'b0, cls: CLS_ADDI};
    end else if (raw == 9'b000000000) begin
      d = '{opcode: OP_NOP, illegal: 1'b0, cls: CLS_NOP};
    end
    return d;
  endfunction

endpackage

// File: rtl/control_word_decoder_if.sv
// Control bundle in / decoded opcode out, each side with a valid/ready handshake.
interface control_word_decoder_if;

  logic       in_valid;
  logic       in_ready;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       Branch;
  logic [1:0] ALUOp;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] OpCode;
  logic       illegal;

  modport master (
    output in_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, ALUOp, out_ready,
    input  in_ready, out_valid, OpCode, illegal
  );

  modport slave (
    input  in_valid, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           Branch, ALUOp, out_ready,
    output in_ready, out_valid, OpCode, illegal
  );

endinterface

// File: rtl/ctrl_class_counter.sv
// One saturating statistics counter; clear takes priority over increment.
module ctrl_class_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/control_word_decoder.sv
// Reconstructs the opcode from a registered control bundle, flags illegal
// bundles and, when CTRL_DEC_STATS_EN is defined, keeps per-class counters.
module control_word_decoder
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  control_word_decoder_if.slave  bus,
  input  logic                   err_clr,
  output logic                   err_sticky,
  input  logic [2:0]             cnt_sel,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       cnt_value
);

  ctrl_bundle_t bundle;
  decode_t      dec;
  logic         accept;
  logic         out_valid_q;
  logic [2:0]   opcode_q;
  logic         illegal_q;

  assign bundle = '{
    reg_dst:    bus.RegDst,
    alu_src:    bus.ALUSrc,
    mem_to_reg: bus.MemtoReg,
    reg_write:  bus.RegWrite,
    mem_read:   bus.MemRead,
    mem_write:  bus.MemWrite,
    branch:     bus.Branch,
    alu_op:     bus.ALUOp
  };
  assign dec = decode_bundle(bundle);

  // A consumed output frees the stage in the same cycle, so no bubble.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= OP_RTYPE;
      illegal_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      opcode_q    <= dec.opcode;
      illegal_q   <= dec.illegal;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (accept && dec.illegal) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.OpCode    = opcode_q;
  assign bus.illegal   = illegal_q;

`ifdef CTRL_DEC_STATS_EN
  logic [NUM_CLASSES-1:0] inc;
  logic [CNT_W-1:0]       counts [NUM_CLASSES];

  for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_cnt
    if (i == int'(CLS_TOTAL)) begin : g_total
      assign inc[i] = accept;
    end else begin : g_class
      assign inc[i] = accept && (dec.cls == 3'(i));
    end

    ctrl_class_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .clr   (cnt_clr),
      .count (counts[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_value <= '0;
    end else begin
      cnt_value <= counts[cnt_sel];
    end
  end
`else
  logic unused_stats;
  assign unused_stats = ^{cnt_sel, cnt_clr, dec.cls};
  assign cnt_value    = '0;
`endif

endmodule

// File: tb/tb_control_word_decoder.sv
// Directed self-checking bench for control_word_decoder (CNT_W = 4 build);
// counter expectations collapse to 0 when CTRL_DEC_STATS_EN is undefined.
module tb_control_word_decoder;

  localparam int CNT_W = 4;
`ifdef CTRL_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Field order: RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp
  localparam logic [8:0] V_RTYPE  = 9'b100100010;
  localparam logic [8:0] V_LW     = 9'b011110000;
  localparam logic [8:0] V_SW     = 9'b010001000;
  localparam logic [8:0] V_BEQ    = 9'b000000101;
  localparam logic [8:0] V_ADDI   = 9'b010100000;
  localparam logic [8:0] V_NOP    = 9'b000000000;
  localparam logic [8:0] V_SW_X   = 9'b111001000;
  localparam logic [8:0] V_R_MW   = 9'b100101010;
  localparam logic [8:0] V_ALL1   = 9'b111111111;

  logic             clk = 1'b0;
  logic             rst;
  logic             err_clr;
  logic             err_sticky;
  logic [2:0]       cnt_sel;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt_value;

  int checks = 0;
  int errors = 0;

  logic [8:0]  legal_vec [6];
  logic [31:0] legal_op  [6];
  logic [31:0] cnt_exp1  [8];

  control_word_decoder_if bus ();

  control_word_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .err_clr    (err_clr),
    .err_sticky (err_sticky),
    .cnt_sel    (cnt_sel),
    .cnt_clr    (cnt_clr),
    .cnt_value  (cnt_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [8:0] v);
    {bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead,
     bus.MemWrite, bus.Branch, bus.ALUOp} = v;
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    legal_vec = '{V_RTYPE, V_LW, V_SW, V_BEQ, V_ADDI, V_NOP};
    legal_op  = '{32'h0, 32'h4, 32'h5, 32'h7, 32'h6, 32'h1};
    cnt_exp1  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd6};

    rst = 1'b1; err_clr = 1'b0; cnt_sel = 3'd0; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; drive(V_NOP);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_opcode",    32'(bus.OpCode), 0);
    check("rst_illegal",   32'(bus.illegal), 0);
    check("rst_err",       32'(err_sticky), 0);
    check("rst_cnt",       32'(cnt_value), 0);
    check("rst_in_ready",  32'(bus.in_ready), 1);

    // Six legal bundles back-to-back
    bus.in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(legal_vec[k]);
      tick();
      check("seq_opcode",  32'(bus.OpCode), legal_op[k]);
      check("seq_illegal", 32'(bus.illegal), 0);
      check("seq_valid",   32'(bus.out_valid), 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("seq_drain", 32'(bus.out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      cnt_sel = 3'(i);
      tick();
      check("seq_cnt", 32'(cnt_value), exp_cnt(int'(cnt_exp1[i])));
    end

    // Don't-care fields and an illegal bundle
    bus.in_valid = 1'b1; drive(V_SW_X);
    tick();
    check("sw_x_opcode",  32'(bus.OpCode), 32'h5);
    check("sw_x_illegal", 32'(bus.illegal), 0);
    drive(V_R_MW);
    tick();
    check("ill_opcode",  32'(bus.OpCode), 0);
    check("ill_illegal", 32'(bus.illegal), 1);
    check("ill_err",     32'(err_sticky), 1);
    bus.in_valid = 1'b0; err_clr = 1'b1;
    tick();
    check("err_clear", 32'(err_sticky), 0);
    bus.in_valid = 1'b1; drive(V_ALL1);
    tick();
    check("err_set_wins", 32'(err_sticky), 1);
    check("all1_illegal", 32'(bus.illegal), 1);
    err_clr = 1'b0; bus.in_valid = 1'b0;
    tick();
    cnt_sel = 3'd6; tick(); check("cnt_illegal", 32'(cnt_value), exp_cnt(2));
    cnt_sel = 3'd2; tick(); check("cnt_sw",      32'(cnt_value), exp_cnt(2));
    cnt_sel = 3'd7; tick(); check("cnt_total",   32'(cnt_value), exp_cnt(9));

    // Backpressure: output holds while out_ready is low
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; drive(V_LW);
    tick();
    check("stall_first", 32'(bus.OpCode), 32'h4);
    drive(V_BEQ);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_valid",    32'(bus.out_valid), 1);
      check("stall_in_ready", 32'(bus.in_ready), 0);
      check("stall_opcode",   32'(bus.OpCode), 32'h4);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(bus.in_ready), 1);
    tick();
    check("release_opcode", 32'(bus.OpCode), 32'h7);
    bus.in_valid = 1'b0;
    tick();
    check("release_drain", 32'(bus.out_valid), 0);

    // Saturation: 2^CNT_W + 3 LW bundles
    bus.in_valid = 1'b1; drive(V_LW);
    repeat ((1 << CNT_W) + 3) tick();
    bus.in_valid = 1'b0;
    tick();
    cnt_sel = 3'd1; tick(); check("sat_lw",    32'(cnt_value), exp_cnt(15));
    cnt_sel = 3'd7; tick(); check("sat_total", 32'(cnt_value), exp_cnt(15));
    cnt_sel = 3'd3; tick(); check("sat_beq",   32'(cnt_value), exp_cnt(2));

    // Clear coinciding with an accept
    bus.in_valid = 1'b1; drive(V_NOP); cnt_clr = 1'b1;
    tick();
    check("clr_opcode", 32'(bus.OpCode), 32'h1);
    cnt_clr = 1'b0; bus.in_valid = 1'b0;
    cnt_sel = 3'd5; tick(); check("clr_nop",   32'(cnt_value), 0);
    cnt_sel = 3'd7; tick(); check("clr_total", 32'(cnt_value), 0);
    cnt_sel = 3'd1; tick(); check("clr_lw",    32'(cnt_value), 0);

    // Reset while a result is pending
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; drive(V_ALL1); cnt_sel = 3'd6;
    tick();
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    check("pre_rst_err",   32'(err_sticky), 1);
    bus.in_valid = 1'b0;
    tick();
    check("pre_rst_cnt", 32'(cnt_value), exp_cnt(1));
    rst = 1'b1;
    tick();
    check("mid_rst_valid",   32'(bus.out_valid), 0);
    check("mid_rst_err",     32'(err_sticky), 0);
    check("mid_rst_cnt",     32'(cnt_value), 0);
    check("mid_rst_opcode",  32'(bus.OpCode), 0);
    check("mid_rst_illegal", 32'(bus.illegal), 0);
    rst = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("post_rst_cnt",      32'(cnt_value), 0);
    bus.in_valid = 1'b1; drive(V_RTYPE);
    tick();
    check("post_rst_opcode",  32'(bus.OpCode), 0);
    check("post_rst_illegal", 32'(bus.illegal), 0);
    bus.in_valid = 1'b0;
    cnt_sel = 3'd0; tick(); check("post_rst_cnt_r",     32'(cnt_value), exp_cnt(1));
    cnt_sel = 3'd7; tick(); check("post_rst_cnt_total", 32'(cnt_value), exp_cnt(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_word_decoder.md
# control_word_decoder

Reverse-direction companion to the control unit: accepts the registered control bundle (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp) and reconstructs the 3-bit OpCode that produced it. It flags bundles that no legal opcode can produce and keeps optional per-class statistics. It sits on the datapath monitor path after the ID/EX register and uses a one-entry valid/ready output stage.

## Interface
- CNT_W, 16, width of each per-class saturating counter
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  control bundle valid
- in_ready  out  1  decoder can accept a bundle this cycle
- RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  control bundle fields
- ALUOp  in  2  control bundle ALU op
- out_valid  out  1  decoded result valid
- out_ready  in  1  consumer accepts result
- OpCode  out  3  reconstructed opcode (3'b000 when illegal)
- illegal  out  1  bundle matches no legal opcode
- err_sticky  out  1  set on any accepted illegal bundle
- err_clr  in  1  clears err_sticky
- cnt_sel  in  3  counter select: 0..5 opcode class per list below, 6 illegal, 7 total
- cnt_clr  in  1  clears all counters
- cnt_value  out  CNT_W  selected counter, registered

## Operation
- Legal encodings, fields RegDst ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp; x = ignored:
  - 000 R-type: 1 0 0 1 0 0 0 10 (class 0)
  - 100 LW: 0 1 1 1 1 0 0 00 (class 1)
  - 101 SW: x 1 x 0 0 1 0 00 (class 2)
  - 111 BEQ: x 0 x 0 0 0 1 01 (class 3)
  - 110 ADDI: 0 1 0 1 0 0 0 00 (class 4)
  - 001 NOP: 0 0 0 0 0 0 0 00 (class 5)
- Any other bundle: illegal=1, OpCode=3'b000.
- Matching is exact; at most one encoding matches any bundle.
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready.
- On accept: OpCode, illegal and out_valid=1 are registered.
- On out_valid && out_ready with no new accept: out_valid clears to 0.
- Outputs hold stable while out_valid && !out_ready.
- err_sticky sets on an accepted illegal bundle. err_clr clears it; a simultaneous set wins.
- Counters (CNT_W each) increment once per accepted bundle:
  - the matching class counter, or illegal (6),
  - total (7) on every accept.
- Counters saturate at all-ones; no wrap.
- cnt_clr zeroes all counters; a simultaneous increment is discarded (result 0).

## Timing
- Latency 1 cycle from accept to out_valid.
- Full throughput (1/cycle) when out_ready held high.
- Back-to-back accept while output is consumed in the same cycle is allowed; no bubble.
- cnt_value updates the cycle after a change of cnt_sel or counter contents (1-cycle registered read).
- Reset values:
  - out_valid=0, OpCode=0, illegal=0, err_sticky=0, cnt_value=0, all counters 0
  - in_ready=1 the cycle after rst deasserts
- rst mid-transfer: the pending result is dropped and counters are zeroed; the next accept behaves as the first after reset.

## Configuration
- CTRL_DEC_STATS_EN defined:
  - counters, cnt_clr and cnt_sel are functional, as above.
- Not defined:
  - no counter storage is synthesized; cnt_value is constant 0.
  - cnt_sel and cnt_clr are ignored.
  - decode, handshake and err_sticky are unchanged.

## Structure
- Shared package ctrl_pkg:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_NOP)
  - control-bundle typedef
  - class-index constants (0..7)
- Submodule ctrl_class_counter: one CNT_W saturating counter with inc/clr and clr priority, instantiated 8 times under CTRL_DEC_STATS_EN.

## Test plan
- Reset, then drive the six legal bundles back-to-back with out_ready=1 → OpCode 000,100,101,111,110,001 one cycle later each, illegal=0, counters 0..5 =1, total=6.
- SW bundle with RegDst=1, MemtoReg=1 → OpCode=101, illegal=0. Bundle R-type with MemWrite=1 → illegal=1, OpCode=000, err_sticky=1, counter 6 =1.
- Hold out_ready=0 with in_valid=1 → out_valid=1, in_ready=0, OpCode stable over 5 cycles. Raise out_ready → next bundle accepted the same cycle.
- Drive 2^CNT_W+3 LW bundles (CNT_W=4 build) → counter 1 reads 15. Then assert cnt_clr together with an accept → all counters 0.
- Assert rst while out_valid=1, out_ready=0 → next cycle out_valid=0, err_sticky=0, cnt_value=0.
- Build without CTRL_DEC_STATS_EN, repeat the first scenario → identical OpCode stream, cnt_value=0 for every cnt_sel.
